// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb
//   Arbitrates the single register-file write port between three sources:
//   the execute pipeline (highest priority, no back-pressure), a multi-cycle
//   unit (MDU) and a debug port. MDU and debug share round-robin priority
//   whenever the pipeline does not take the port. A starvation counter stalls
//   the pipeline for one cycle once a lower requester has been blocked
//   STARVE_LIMIT cycles in a row.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid/ex_rd/ex_wd       pipeline writeback request (always accepted unless stalled)
//   mdu_valid/mdu_rd/mdu_wd    MDU write request, mdu_ready = accepted this cycle
//   dbg_valid/dbg_rd/dbg_wd    debug write request, dbg_ready = accepted this cycle
//   a3/wd3/we3                 registered register-file write port (one cycle after accept)
//   stall_pipe                 pipeline must keep ex_valid low while this is high
//   proto_err                  sticky: ex_valid was seen high during a stall cycle
module regfile_wport_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_wd,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_wd,
  output logic              mdu_ready,
  input  logic              dbg_valid,
  input  logic [4:0]        dbg_rd,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_ready,
  output logic [4:0]        a3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3,
  output logic              stall_pipe,
  output logic              proto_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        cnt;
  logic              last_dbg;   // 1: debug was the most recent lower-priority grant

  logic              ex_acc_p0;
  logic              mdu_win;
  logic              grant_lo;
  logic              vld_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] wd_p0;

  // ---- stage p0: arbitration and source select (combinational) ----
  always_comb begin
    stall_pipe = (cnt == LIMIT);
    ex_acc_p0  = ex_valid & ~stall_pipe & ~reset;
    // MDU takes the slot if it is alone, or on a tie when debug went last.
    mdu_win    = mdu_valid & (~dbg_valid | last_dbg);
    mdu_ready  = ~reset & ~ex_acc_p0 & mdu_win;
    dbg_ready  = ~reset & ~ex_acc_p0 & dbg_valid & ~mdu_win;
    grant_lo   = mdu_ready | dbg_ready;
    vld_p0     = ex_acc_p0 | grant_lo;

    rd_p0 = ex_rd;
    wd_p0 = ex_wd;
    if (mdu_ready) begin
      rd_p0 = mdu_rd;
      wd_p0 = mdu_wd;
    end else if (dbg_ready) begin
      rd_p0 = dbg_rd;
      wd_p0 = dbg_wd;
    end
  end

  // ---- stage p1: write-port register and arbitration state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      we3       <= 1'b0;
      a3        <= '0;
      wd3       <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
      last_dbg  <= 1'b1;
    end else begin
      // A write to x0 is consumed but never reaches the port; a3/wd3 hold.
      we3 <= vld_p0 & (rd_p0 != 5'd0);
      if (vld_p0 && rd_p0 != 5'd0) begin
        a3  <= rd_p0;
        wd3 <= wd_p0;
      end

      if (ex_valid && stall_pipe)
        proto_err <= 1'b1;

      if (grant_lo || !(mdu_valid || dbg_valid))
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + 4'd1;

      if (mdu_ready)
        last_dbg <= 1'b0;
      else if (dbg_ready)
        last_dbg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Testbench for regfile_wport_arb: a table of hand-computed cycle vectors,
// a hand-written starvation sequence, then randomized traffic checked
// against a behavioural reference model.
module tb_regfile_wport_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, mdu_valid, dbg_valid;
  logic [4:0]  ex_rd, mdu_rd, dbg_rd;
  logic [31:0] ex_wd, mdu_wd, dbg_wd;
  logic        mdu_ready, dbg_ready, we3, stall_pipe, proto_err;
  logic [4:0]  a3;
  logic [31:0] wd3;

  always #5 clk = ~clk;

  regfile_wport_arb #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wd(ex_wd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_wd(dbg_wd), .dbg_ready(dbg_ready),
    .a3(a3), .wd3(wd3), .we3(we3), .stall_pipe(stall_pipe), .proto_err(proto_err)
  );

  typedef struct {
    logic        rst;
    logic        exv;  logic [4:0] exrd; logic [31:0] exwd;
    logic        mv;   logic [4:0] mrd;  logic [31:0] mwd;
    logic        dv;   logic [4:0] drd;  logic [31:0] dwd;
    logic        e_mr, e_dr, e_st, e_we;
    logic [4:0]  e_a;  logic [31:0] e_wd;
    logic        e_perr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: who wins is decided from the rules directly.
  int          m_starve;
  bit          m_last_dbg;
  bit          m_perr;
  bit          m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  bit          m_st, m_mr, m_dr;
  int          m_win;   // 0 none, 1 ex, 2 mdu, 3 dbg

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_comb(input vec_t v);
    m_st  = (m_starve == LIMIT);
    m_win = 0;
    if (!v.rst) begin
      if (v.exv && !m_st)   m_win = 1;
      else if (v.mv && v.dv) m_win = m_last_dbg ? 2 : 3;
      else if (v.mv)        m_win = 2;
      else if (v.dv)        m_win = 3;
    end
    m_mr = (m_win == 2);
    m_dr = (m_win == 3);
  endtask

  task automatic model_update(input vec_t v);
    logic [4:0]  rd;
    logic [31:0] wd;
    if (v.rst) begin
      m_we = 0; m_a = '0; m_wd = '0;
      m_starve = 0; m_perr = 0; m_last_dbg = 1;
      return;
    end
    if (v.exv && m_st) m_perr = 1;
    case (m_win)
      1: begin rd = v.exrd; wd = v.exwd; end
      2: begin rd = v.mrd;  wd = v.mwd;  end
      3: begin rd = v.drd;  wd = v.dwd;  end
      default: begin rd = '0; wd = '0; end
    endcase
    m_we = (m_win != 0) && (rd != 0);
    if (m_we) begin m_a = rd; m_wd = wd; end
    if (m_win >= 2 || !(v.mv || v.dv)) m_starve = 0;
    else if (m_starve < LIMIT)         m_starve++;
    if (m_win == 2) m_last_dbg = 0;
    if (m_win == 3) m_last_dbg = 1;
  endtask

  // Entered at posedge+1; drives, checks combinational outputs, clocks,
  // then checks the registered outputs at the next posedge+1.
  task automatic do_cycle(input vec_t v, input bit use_tab, input bit check);
    reset = v.rst;
    ex_valid = v.exv;  ex_rd = v.exrd; ex_wd = v.exwd;
    mdu_valid = v.mv;  mdu_rd = v.mrd; mdu_wd = v.mwd;
    dbg_valid = v.dv;  dbg_rd = v.drd; dbg_wd = v.dwd;
    #2;
    model_comb(v);
    if (check) begin
      chk("mdu_ready",  32'(mdu_ready),  use_tab ? 32'(v.e_mr) : 32'(m_mr));
      chk("dbg_ready",  32'(dbg_ready),  use_tab ? 32'(v.e_dr) : 32'(m_dr));
      chk("stall_pipe", 32'(stall_pipe), use_tab ? 32'(v.e_st) : 32'(m_st));
    end
    model_update(v);
    @(posedge clk);
    #1;
    if (check) begin
      chk("we3",       32'(we3),       use_tab ? 32'(v.e_we)   : 32'(m_we));
      chk("a3",        32'(a3),        use_tab ? 32'(v.e_a)    : 32'(m_a));
      chk("wd3",       wd3,            use_tab ? v.e_wd        : m_wd);
      chk("proto_err", 32'(proto_err), use_tab ? 32'(v.e_perr) : 32'(m_perr));
    end
  endtask

  function automatic vec_t mk(
      input logic rst, input logic exv, input logic [4:0] exrd, input logic [31:0] exwd,
      input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
      input logic dv, input logic [4:0] drd, input logic [31:0] dwd,
      input logic e_mr, input logic e_dr, input logic e_st, input logic e_we,
      input logic [4:0] e_a, input logic [31:0] e_wd, input logic e_perr);
    vec_t v;
    v.rst = rst; v.exv = exv; v.exrd = exrd; v.exwd = exwd;
    v.mv = mv; v.mrd = mrd; v.mwd = mwd;
    v.dv = dv; v.drd = drd; v.dwd = dwd;
    v.e_mr = e_mr; v.e_dr = e_dr; v.e_st = e_st; v.e_we = e_we;
    v.e_a = e_a; v.e_wd = e_wd; v.e_perr = e_perr;
    return v;
  endfunction

  vec_t tab[26];
  vec_t idle;

  initial begin
    vec_t v;
    bit pm_v, pd_v;
    logic [4:0]  pm_rd, pd_rd;
    logic [31:0] pm_wd, pd_wd;

    //            rst exv rd  wd            mv rd  wd     dv rd  wd            mr dr st we a   wd            perr
    tab[0]  = mk(1, 0, 0, 0,             0, 0, 0,      0, 0, 0,             0, 0, 0, 0, 0,  0,            0);
    tab[1]  = mk(0, 1, 5, 32'h1234,      0, 0, 0,      0, 0, 0,             0, 0, 0, 1, 5,  32'h1234,     0);
    tab[2]  = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0,             0, 0, 0, 0, 5,  32'h1234,     0);
    tab[3]  = mk(0, 0, 0, 0,             1, 1, 32'hA1, 1, 2, 32'hB2,        1, 0, 0, 1, 1,  32'hA1,       0);
    tab[4]  = mk(0, 0, 0, 0,             1, 1, 32'hA1, 1, 2, 32'hB2,        0, 1, 0, 1, 2,  32'hB2,       0);
    tab[5]  = mk(0, 0, 0, 0,             1, 1, 32'hA1, 1, 2, 32'hB2,        1, 0, 0, 1, 1,  32'hA1,       0);
    tab[6]  = mk(0, 0, 0, 0,             1, 1, 32'hA1, 1, 2, 32'hB2,        0, 1, 0, 1, 2,  32'hB2,       0);
    tab[7]  = mk(0, 0, 0, 0,             0, 0, 0,      1, 0, 32'hFFFFFFFF,  0, 1, 0, 0, 2,  32'hB2,       0);
    tab[8]  = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0,             0, 0, 0, 0, 2,  32'hB2,       0);
    tab[9]  = mk(0, 1, 3, 32'h33,        1, 7, 32'h77, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[10] = mk(0, 1, 3, 32'h33,        1, 7, 32'h77, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[11] = mk(0, 1, 3, 32'h33,        1, 7, 32'h77, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[12] = mk(0, 1, 3, 32'h33,        1, 7, 32'h77, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[13] = mk(0, 0, 3, 32'h33,        1, 7, 32'h77, 0, 0, 0,             1, 0, 1, 1, 7,  32'h77,       0);
    tab[14] = mk(0, 1, 4, 32'h44,        0, 0, 0,      0, 0, 0,             0, 0, 0, 1, 4,  32'h44,       0);
    tab[15] = mk(0, 1, 3, 32'h33,        1, 8, 32'h88, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[16] = mk(0, 1, 3, 32'h33,        1, 8, 32'h88, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[17] = mk(0, 1, 3, 32'h33,        1, 8, 32'h88, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[18] = mk(0, 1, 3, 32'h33,        1, 8, 32'h88, 0, 0, 0,             0, 0, 0, 1, 3,  32'h33,       0);
    tab[19] = mk(0, 1, 9, 32'h99,        1, 8, 32'h88, 0, 0, 0,             1, 0, 1, 1, 8,  32'h88,       1);
    tab[20] = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0,             0, 0, 0, 0, 8,  32'h88,       1);
    tab[21] = mk(0, 1, 10, 32'hAA,       0, 0, 0,      0, 0, 0,             0, 0, 0, 1, 10, 32'hAA,       1);
    tab[22] = mk(1, 0, 0, 0,             1, 11, 32'hBB, 0, 0, 0,            0, 0, 0, 0, 0,  0,            0);
    tab[23] = mk(0, 0, 0, 0,             1, 11, 32'hBB, 1, 12, 32'hCC,      1, 0, 0, 1, 11, 32'hBB,       0);
    tab[24] = mk(0, 0, 0, 0,             0, 0, 0,      1, 12, 32'hCC,       0, 1, 0, 1, 12, 32'hCC,       0);
    tab[25] = mk(0, 0, 0, 0,             0, 0, 0,      0, 0, 0,             0, 0, 0, 0, 12, 32'hCC,       0);

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1; ex_valid = 0; ex_rd = 0; ex_wd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
    dbg_valid = 0; dbg_rd = 0; dbg_wd = 0;
    @(posedge clk); #1;
    v = idle; v.rst = 1;
    do_cycle(v, 0, 0);   // settle DUT and model into a known reset state

    for (int i = 0; i < 26; i++) do_cycle(tab[i], 1, 1);

    // Debug starves behind the pipeline, then withdraws in the stall cycle:
    // nothing is granted, the pipeline slot is lost, and stall releases.
    for (int i = 0; i < LIMIT; i++) begin
      v = idle; v.exv = 1; v.exrd = 5'(20 + i); v.exwd = 32'(i + 100);
      v.dv = 1; v.drd = 13; v.dwd = 32'hD0D0;
      do_cycle(v, 0, 1);
    end
    v = idle;
    do_cycle(v, 0, 1);
    chk("drop_in_stall_st", 32'(m_st), 32'd1);
    chk("drop_in_stall_we3", 32'(we3), 32'd0);
    do_cycle(idle, 0, 1);
    chk("after_drop_stall", 32'(stall_pipe), 32'd0);

    // Randomized traffic against the model. Lower requesters hold rd/data
    // until granted, and occasionally withdraw.
    pm_v = 0; pd_v = 0; pm_rd = 0; pd_rd = 0; pm_wd = 0; pd_wd = 0;
    for (int c = 0; c < 2000; c++) begin
      v = idle;
      v.rst = ($urandom_range(0, 99) == 0);
      if (!pm_v) begin
        if ($urandom_range(0, 1) == 1) begin
          pm_v = 1; pm_rd = 5'($urandom_range(0, 31)); pm_wd = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) pm_v = 0;
      if (!pd_v) begin
        if ($urandom_range(0, 2) == 0) begin
          pd_v = 1; pd_rd = 5'($urandom_range(0, 31)); pd_wd = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) pd_v = 0;
      v.mv = pm_v; v.mrd = pm_rd; v.mwd = pm_wd;
      v.dv = pd_v; v.drd = pd_rd; v.dwd = pd_wd;
      if (m_starve == LIMIT) v.exv = ($urandom_range(0, 19) == 0);
      else                   v.exv = ($urandom_range(0, 9) < 7);
      v.exrd = 5'($urandom_range(0, 31));
      v.exwd = $urandom;
      do_cycle(v, 0, 1);
      if (m_win == 2) pm_v = 0;
      if (m_win == 3) pd_v = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arb.md
REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, legal range 1..15; the number of consecutive blocked cycles a lower-priority requester tolerates before the pipeline is stalled.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_valid  in  1  pipeline writeback request; has no ready signal.
REQ-005 ex_rd  in  5  pipeline destination register.
REQ-006 ex_wd  in  32  pipeline write data.
REQ-007 mdu_valid / mdu_rd / mdu_wd  in  1/5/32  multi-cycle unit write request, rd, data.
REQ-008 mdu_ready  out  1  MDU request accepted this cycle.
REQ-009 dbg_valid / dbg_rd / dbg_wd  in  1/5/32  debug-port write request, rd, data.
REQ-010 dbg_ready  out  1  debug request accepted this cycle.
REQ-011 a3 / wd3 / we3  out  5/32/1  registered drive of the register-file write port.
REQ-012 stall_pipe  out  1  pipeline shall hold ex_valid low in any cycle where this is high.
REQ-013 proto_err  out  1  sticky flag: ex_valid was seen high while stall_pipe was high.

Function
REQ-014 Handshake: an MDU or debug transfer occurs in a cycle where valid and ready are both high; the requester holds rd and data stable until that cycle.
REQ-015 mdu_ready and dbg_ready are combinational from the current valids and state; at most one of them is high in any cycle.
REQ-016 An ex_valid request is always accepted when stall_pipe is low, and then both mdu_ready and dbg_ready are low.
REQ-017 When ex is not accepted, the lower requesters are arbitrated round-robin:
- If only one lower requester is valid, it is granted.
- If both are valid, the one not granted last time wins.
- The last-granted pointer updates only on a lower-priority grant; its reset value is "debug", so MDU wins the first tie.
REQ-018 Latency: a request accepted in cycle N appears on a3/wd3/we3 in cycle N+1 for exactly one cycle.
- we3 is 0 in cycle N+1 when nothing is accepted in cycle N.
- a3 and wd3 hold their previous values when we3 is 0.
REQ-019 Writes to rd=0 are accepted (ready or ex consumed normally), but the following cycle has we3=0.
REQ-020 Starvation counter cnt (4 bits):
- Increments each cycle in which mdu_valid or dbg_valid is high and no lower grant occurs.
- Clears in any cycle with a lower grant, or when neither lower valid is high.
- Saturates at STARVE_LIMIT.
REQ-021 stall_pipe = (cnt == STARVE_LIMIT).
- In a stall cycle, ex is ignored and the round-robin winner is granted; cnt clears.
- If ex_valid is high in a stall cycle, the ex request is dropped and proto_err sets.
REQ-022 A lower requester dropping valid before being granted is legal; its request is not remembered.
REQ-023 No internal buffering: the block holds at most one write in flight (the output register).

Reset
REQ-024 While reset is high in a posedge cycle, the following take effect at that edge:
- we3=0, a3=0, wd3=0.
- cnt=0, so stall_pipe=0.
- proto_err=0.
- Round-robin pointer = debug.
REQ-025 During a reset cycle, mdu_ready=0 and dbg_ready=0, and no request is accepted; an in-flight output write is cancelled (we3=0 on the cycle after reset).

Verification
REQ-026 ex_valid=1, ex_rd=5, ex_wd=0x1234 in cycle N -> a3=5, wd3=0x1234, we3=1 in cycle N+1; mdu_ready=dbg_ready=0 in N.
REQ-027 mdu_valid and dbg_valid both held high with ex idle, for 4 cycles after reset -> grants in order MDU, DBG, MDU, DBG; we3=1 on each following cycle with the matching rd/data.
REQ-028 STARVE_LIMIT=4, ex_valid=1 every cycle, mdu_valid=1 continuously:
- cnt reaches 4 after 4 blocked cycles.
- stall_pipe=1 in the 5th cycle; if the bench obeys stall_pipe by dropping ex_valid, mdu_ready=1 in that cycle.
- Next cycle: stall_pipe=0 and we3 carries the MDU write.
REQ-029 Same as REQ-028, but the bench keeps ex_valid=1 during the stall cycle -> MDU granted, ex write absent from the port, proto_err=1 and it remains 1 until reset.
REQ-030 dbg_valid=1, dbg_rd=0, dbg_wd=0xFFFFFFFF -> dbg_ready=1 that cycle, we3=0 the next cycle.
REQ-031 Reset asserted in the cycle an MDU request is being accepted -> mdu_ready=0, we3=0 after reset, cnt=0, and after reset deasserts the MDU is granted on its first valid cycle.
